// File: rtl/frame_fill_sequencer.sv
// Sole owner of the frame buffer write port: arbitrates full-screen clear against rectangle fill
// and streams one pixel write per cycle. Outputs are registered, so hold suppresses the next cycle's write.
module frame_fill_sequencer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clr_req,
  input  logic [7:0]        clr_color,
  input  logic              rect_req,
  input  logic [9:0]        rect_x,
  input  logic [9:0]        rect_y,
  input  logic [9:0]        rect_w,
  input  logic [9:0]        rect_h,
  input  logic [7:0]        rect_color,
  input  logic              hold,
  output logic              clr_ack,
  output logic              rect_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] frame_wraddress,
  output logic [7:0]        frame_data,
  output logic              frame_we
);

  typedef enum logic [1:0] {IDLE, CLEAR, RECT, DONE} state_t;

  localparam logic [10:0]       H_END    = 11'(H_RES);
  localparam logic [10:0]       V_END    = 11'(V_RES);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  state_t            state_q, state_d;
  logic [9:0]        col_q, col_d, row_q, row_d, x_start_q, x_start_d;
  logic [10:0]       x_end_q, x_end_d, y_end_q, y_end_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic [7:0]        color_q, color_d, data_q, data_d;
  logic              is_rect_q, is_rect_d, fin_q, fin_d, we_q, we_d;
  logic              clr_ack_q, clr_ack_d, rect_ack_q, rect_ack_d, busy_q, busy_d;
  logic              issue;
  logic [10:0]       x_sum, y_sum;
  logic              rect_empty;

  assign x_sum      = {1'b0, rect_x} + {1'b0, rect_w};
  assign y_sum      = {1'b0, rect_y} + {1'b0, rect_h};
  assign rect_empty = (rect_w == 10'd0) || (rect_h == 10'd0) ||
                      ({1'b0, rect_x} >= H_END) || ({1'b0, rect_y} >= V_END);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    x_start_d  = x_start_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    color_d    = color_q;
    is_rect_d  = is_rect_q;
    fin_d      = fin_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    clr_ack_d  = 1'b0;
    rect_ack_d = 1'b0;
    busy_d     = 1'b1;
    issue      = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (clr_req) begin
          busy_d     = 1'b1;
          state_d    = CLEAR;
          is_rect_d  = 1'b0;
          color_d    = clr_color;
          col_d      = 10'd0;
          row_d      = 10'd0;
          x_start_d  = 10'd0;
          row_base_d = '0;
          x_end_d    = H_END;
          y_end_d    = V_END;
          fin_d      = 1'b0;
          issue      = ~hold;
        end else if (rect_req) begin
          busy_d     = 1'b1;
          is_rect_d  = 1'b1;
          color_d    = rect_color;
          col_d      = rect_x;
          row_d      = rect_y;
          x_start_d  = rect_x;
          // y*640 as two shifted copies of y
          row_base_d = (ADDR_W'(rect_y) << 9) + (ADDR_W'(rect_y) << 7);
          x_end_d    = (x_sum > H_END) ? H_END : x_sum;
          y_end_d    = (y_sum > V_END) ? V_END : y_sum;
          fin_d      = 1'b0;
          if (rect_empty) begin
            state_d    = DONE;
            rect_ack_d = 1'b1;
          end else begin
            state_d = RECT;
            issue   = ~hold;
          end
        end
      end
      CLEAR, RECT: begin
        if (fin_q) begin
          state_d    = DONE;
          clr_ack_d  = ~is_rect_q;
          rect_ack_d = is_rect_q;
        end else begin
          issue = ~hold;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // col/row always name the next pixel to issue; fin marks that the last one has gone out
    if (issue) begin
      we_d   = 1'b1;
      addr_d = row_base_d + ADDR_W'(col_d);
      data_d = color_d;
      if ({1'b0, col_d} == x_end_d - 11'd1) begin
        if ({1'b0, row_d} + 11'd1 == y_end_d) fin_d = 1'b1;
        col_d      = x_start_d;
        row_d      = row_d + 10'd1;
        row_base_d = row_base_d + ROW_STEP;
      end else begin
        col_d = col_d + 10'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      x_start_q  <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      color_q    <= '0;
      is_rect_q  <= 1'b0;
      fin_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      clr_ack_q  <= 1'b0;
      rect_ack_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      x_start_q  <= x_start_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      color_q    <= color_d;
      is_rect_q  <= is_rect_d;
      fin_q      <= fin_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      clr_ack_q  <= clr_ack_d;
      rect_ack_q <= rect_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign frame_we        = we_q;
  assign frame_wraddress = addr_q;
  assign frame_data      = data_q;
  assign clr_ack         = clr_ack_q;
  assign rect_ack        = rect_ack_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_frame_fill_sequencer.sv
// Scoreboard bench for frame_fill_sequencer; V_RES is reduced to 32 lines so a full clear stays short.
module tb_frame_fill_sequencer;
  localparam int H_RES  = 640;
  localparam int V_RES  = 32;
  localparam int ADDR_W = 19;
  localparam int N_CLR  = H_RES * V_RES;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              clr_req, rect_req, hold;
  logic [7:0]        clr_color, rect_color;
  logic [9:0]        rect_x, rect_y, rect_w, rect_h;
  logic              clr_ack, rect_ack, busy, frame_we;
  logic [ADDR_W-1:0] frame_wraddress;
  logic [7:0]        frame_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;

  logic [26:0] exp_wr_q[$];
  bit          exp_ack_q[$];
  logic [26:0] e_wr;
  bit          e_ack;

  frame_fill_sequencer #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .clr_req(clr_req), .clr_color(clr_color),
    .rect_req(rect_req), .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_color(rect_color), .hold(hold),
    .clr_ack(clr_ack), .rect_ack(rect_ack), .busy(busy),
    .frame_wraddress(frame_wraddress), .frame_data(frame_data), .frame_we(frame_we)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every ack is matched against the scoreboard in order
  always @(negedge Clk) begin
    if (!Reset) begin
      if (frame_we) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", frame_wraddress, frame_data);
        end else begin
          e_wr = exp_wr_q.pop_front();
          check("wr_addr", frame_wraddress, e_wr[26:8]);
          check("wr_data", frame_data, e_wr[7:0]);
        end
      end
      if (clr_ack || rect_ack) begin
        if (exp_ack_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got clr_ack=%0b rect_ack=%0b, expected none", clr_ack, rect_ack);
        end else begin
          e_ack = exp_ack_q.pop_front();
          check("ack_kind", {clr_ack, rect_ack}, e_ack ? 2'b01 : 2'b10);
        end
      end
    end
  end

  task automatic push_wr(input int addr, input logic [7:0] d);
    exp_wr_q.push_back({ADDR_W'(addr), d});
  endtask

  // Returns at the negedge after the acceptance edge; acc is the cycle index of the first write.
  task automatic start_rect(input int x, input int y, input int w, input int h,
                            input logic [7:0] c, output int acc);
    @(negedge Clk); #1;
    rect_x = 10'(x); rect_y = 10'(y); rect_w = 10'(w); rect_h = 10'(h);
    rect_color = c; rect_req = 1'b1;
    @(negedge Clk);
    acc = cyc;
  endtask

  task automatic start_clear(input logic [7:0] c, output int acc);
    @(negedge Clk); #1;
    clr_color = c; clr_req = 1'b1;
    @(negedge Clk);
    acc = cyc;
  endtask

  task automatic wait_ack(input string name, input bit is_rect, input int exp_cyc, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (is_rect ? rect_ack : clr_ack) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    check({name, "_ack_seen"}, seen, 1);
    if (seen) begin
      check({name, "_ack_cycle"}, cyc, exp_cyc);
      check({name, "_busy_in_done"}, busy, 1);
    end
  endtask

  task automatic after_done(input string name);
    @(negedge Clk); #1;
    check({name, "_busy_low"}, busy, 0);
    check({name, "_ack_one_cycle"}, clr_ack | rect_ack, 0);
  endtask

  task automatic wait_writes(input string name, input int target, input int budget);
    bit hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge Clk); #1;
      if (wr_cnt >= target) begin
        hit = 1'b1;
        break;
      end
    end
    check({name, "_writes_reached"}, hit, 1);
  endtask

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, base, acks_seen;
    Reset = 1'b1; clr_req = 1'b0; rect_req = 1'b0; hold = 1'b0;
    clr_color = '0; rect_color = '0; rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0;
    repeat (3) @(negedge Clk);
    check("rst_we", frame_we, 0);
    check("rst_addr", frame_wraddress, 0);
    check("rst_data", frame_data, 0);
    check("rst_clr_ack", clr_ack, 0);
    check("rst_rect_ack", rect_ack, 0);
    check("rst_busy", busy, 0);
    #1 Reset = 1'b0;

    // Full clear: N_CLR consecutive writes of 8'h1C
    for (int i = 0; i < N_CLR; i++) push_wr(i, 8'h1C);
    exp_ack_q.push_back(1'b0);
    start_clear(8'h1C, acc);
    wait_ack("clear", 1'b0, acc + N_CLR, N_CLR + 10);
    clr_req = 1'b0;
    after_done("clear");

    // 3x2 rectangle at (10,5)
    push_wr(3210, 8'h2A); push_wr(3211, 8'h2A); push_wr(3212, 8'h2A);
    push_wr(3850, 8'h2A); push_wr(3851, 8'h2A); push_wr(3852, 8'h2A);
    exp_ack_q.push_back(1'b1);
    start_rect(10, 5, 3, 2, 8'h2A, acc);
    wait_ack("rect3x2", 1'b1, acc + 6, 20);
    rect_req = 1'b0;
    after_done("rect3x2");

    // Bottom-right corner: clipped to two pixels
    push_wr((V_RES - 1) * H_RES + 638, 8'h4B);
    push_wr((V_RES - 1) * H_RES + 639, 8'h4B);
    exp_ack_q.push_back(1'b1);
    start_rect(638, V_RES - 1, 5, 4, 8'h4B, acc);
    wait_ack("rect_corner", 1'b1, acc + 2, 20);
    rect_req = 1'b0;
    after_done("rect_corner");

    // Wide rectangle clipped at right edge: columns 600..639 of row 0
    for (int i = 600; i < 640; i++) push_wr(i, 8'h81);
    exp_ack_q.push_back(1'b1);
    start_rect(600, 0, 1000, 1, 8'h81, acc);
    wait_ack("rect_clip_x", 1'b1, acc + 40, 60);
    rect_req = 1'b0;
    after_done("rect_clip_x");

    // Zero width: no writes, ack in the cycle after acceptance
    exp_ack_q.push_back(1'b1);
    start_rect(20, 20, 0, 5, 8'hEE, acc);
    wait_ack("rect_w0", 1'b1, acc, 10);
    rect_req = 1'b0;
    after_done("rect_w0");

    // Off-screen x: no writes
    exp_ack_q.push_back(1'b1);
    start_rect(640, 3, 5, 1, 8'hEE, acc);
    wait_ack("rect_xoff", 1'b1, acc, 10);
    rect_req = 1'b0;
    after_done("rect_xoff");

    // Simultaneous requests: clear wins, pending rect follows after DONE and one IDLE cycle
    for (int i = 0; i < N_CLR; i++) push_wr(i, 8'h03);
    push_wr(1380, 8'h77); push_wr(1381, 8'h77);
    exp_ack_q.push_back(1'b0);
    exp_ack_q.push_back(1'b1);
    @(negedge Clk); #1;
    clr_color = 8'h03; clr_req = 1'b1;
    rect_x = 10'd100; rect_y = 10'd2; rect_w = 10'd2; rect_h = 10'd1; rect_color = 8'h77; rect_req = 1'b1;
    @(negedge Clk);
    acc = cyc;
    wait_ack("simul_clear", 1'b0, acc + N_CLR, N_CLR + 10);
    clr_req = 1'b0;
    after_done("simul_clear");
    wait_ack("simul_rect", 1'b1, acc + N_CLR + 4, 20);
    rect_req = 1'b0;
    after_done("simul_rect");

    // 4x1 rect with a 3-cycle stall after the 2nd write
    push_wr(0, 8'h33); push_wr(1, 8'h33); push_wr(2, 8'h33); push_wr(3, 8'h33);
    exp_ack_q.push_back(1'b1);
    start_rect(0, 0, 4, 1, 8'h33, acc);
    @(negedge Clk); #1;
    check("hold_second_write", frame_we, 1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      check("hold_gap_we", frame_we, 0);
    end
    hold = 1'b0;
    wait_ack("rect_hold", 1'b1, acc + 7, 20);
    rect_req = 1'b0;
    after_done("rect_hold");

    // Reset after 100 clear writes: outputs drop at once, no ack
    base = wr_cnt;
    for (int i = 0; i < 100; i++) push_wr(i, 8'h5A);
    @(negedge Clk); #1;
    clr_color = 8'h5A; clr_req = 1'b1;
    wait_writes("rst_clear", base + 100, 200);
    Reset = 1'b1; clr_req = 1'b0;
    #1;
    check("rst_async_we", frame_we, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_addr", frame_wraddress, 0);
    check("rst_sb_drained", exp_wr_q.size(), 0);
    repeat (2) @(negedge Clk);
    #1 Reset = 1'b0;
    acks_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk); #1;
      if (clr_ack || rect_ack) acks_seen++;
    end
    check("rst_no_ack", acks_seen, 0);

    // Restarted clear begins again at address 0
    base = wr_cnt;
    for (int i = 0; i < 50; i++) push_wr(i, 8'h66);
    @(negedge Clk); #1;
    clr_color = 8'h66; clr_req = 1'b1;
    wait_writes("restart_clear", base + 50, 100);
    Reset = 1'b1; clr_req = 1'b0;
    #1;
    check("restart_sb_drained", exp_wr_q.size(), 0);
    repeat (2) @(negedge Clk);
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clk);

    check("final_wr_queue", exp_wr_q.size(), 0);
    check("final_ack_queue", exp_ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
